// File: rtl/soc_sram_bank.sv
// soc_sram_bank: byte-strobed single-port SRAM bank with valid/ready request and
// response channels, optional output register, clear-after-reset sequencer and an
// in-order response FIFO protected by credit-based request flow control.
module soc_sram_bank #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned WORDS          = 16,
    parameter int unsigned ADDR_W         = 22,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W/8-1:0] req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned DEPTH  = 2 + OUT_REG;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned SLOTS  = 1 << PTR_W;
    localparam int unsigned CRED_W = 3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               run_c, clearing_c, clr_last_c;

    logic [DATA_W-1:0]  mem [WORDS];

    logic               accept_c, in_range_c, pop_c;
    logic [IDX_W-1:0]   idx_c;

    logic               s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]  s1_data_q, s1_data_d;
    logic               s1_err_q, s1_err_d;

    logic               lst_valid_c, lst_err_c, s2_valid_c;
    logic [DATA_W-1:0]  lst_data_c;

    logic [DATA_W-1:0]  fifo_data_q [SLOTS];
    logic               fifo_err_q  [SLOTS];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, cnt_q;
    logic [DATA_W-1:0]  hold_data_q;
    logic               hold_err_q;
    logic [CRED_W-1:0]  credit_c;

    // FSM state register and clear counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // FSM next state: walk every word once, then run until reset
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_last_c) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        run_c      = 1'b0;
        clearing_c = 1'b0;
        clr_last_c = (clr_cnt_q == IDX_W'(WORDS - 1));
        case (state_q)
            ST_CLEAR: clearing_c = 1'b1;
            ST_RUN:   run_c      = 1'b1;
            default:  run_c      = 1'b0;
        endcase
    end

    assign init_done = run_c;

    // Request decode and credit check; new total must never exceed the FIFO depth
    assign idx_c      = req_addr[IDX_W-1:0];
    assign in_range_c = (req_addr < ADDR_W'(WORDS));
    assign pop_c      = rsp_valid && rsp_ready;
    assign credit_c   = CRED_W'(cnt_q) + CRED_W'(s1_valid_q) + CRED_W'(s2_valid_c) - CRED_W'(pop_c);
    assign req_ready  = run_c && (credit_c < CRED_W'(DEPTH));
    assign accept_c   = req_valid && req_ready;

    // Array write port: clear sequencer or byte-strobed request write
    always_ff @(posedge clk) begin
        if (clearing_c) begin
            mem[clr_cnt_q] <= '0;
        end else if (accept_c && in_range_c) begin
            for (int i = 0; i < NB; i++) begin
                if (req_wen[i]) begin
                    mem[idx_c][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-first capture of the addressed word
    always_comb begin
        s1_valid_d = accept_c;
        s1_err_d   = accept_c && !in_range_c;
        s1_data_d  = (accept_c && in_range_c) ? mem[idx_c] : '0;
    end

    // First response stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_err_q   <= s1_err_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic              s2_valid_q;
        logic [DATA_W-1:0] s2_data_q;
        logic              s2_err_q;

        // Optional second response stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
                s2_err_q   <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_data_q  <= s1_data_q;
                s2_err_q   <= s1_err_q;
            end
        end

        assign lst_valid_c = s2_valid_q;
        assign lst_data_c  = s2_data_q;
        assign lst_err_c   = s2_err_q;
        assign s2_valid_c  = s2_valid_q;
    end else begin : g_noreg
        assign lst_valid_c = s1_valid_q;
        assign lst_data_c  = s1_data_q;
        assign lst_err_c   = s1_err_q;
        assign s2_valid_c  = 1'b0;
    end

    // Response FIFO storage; credit flow control guarantees it never overflows
    always_ff @(posedge clk) begin
        if (lst_valid_c) begin
            fifo_data_q[wr_ptr_q] <= lst_data_c;
            fifo_err_q[wr_ptr_q]  <= lst_err_c;
        end
    end

    // Response FIFO pointers, occupancy and last-popped hold value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
        end else begin
            if (lst_valid_c) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q    <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
                hold_data_q <= fifo_data_q[rd_ptr_q];
                hold_err_q  <= fifo_err_q[rd_ptr_q];
            end
            cnt_q <= cnt_q + PTR_W'(lst_valid_c) - PTR_W'(pop_c);
        end
    end

    assign rsp_valid = (cnt_q != '0);
    assign rsp_rdata = rsp_valid ? fifo_data_q[rd_ptr_q] : hold_data_q;
    assign rsp_err   = rsp_valid ? fifo_err_q[rd_ptr_q]  : hold_err_q;

endmodule

// File: tb/tb_soc_sram_bank.sv
// Scoreboard bench for soc_sram_bank (default 32-bit x 16 words, OUT_REG=0).
module tb_soc_sram_bank;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WORDS   = 16;
    localparam int unsigned ADDR_W  = 22;
    localparam int unsigned OUT_REG = 0;
    localparam int unsigned DEPTH   = 2 + OUT_REG;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_wen = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    soc_sram_bank #(
        .DATA_W(DATA_W), .WORDS(WORDS), .ADDR_W(ADDR_W),
        .OUT_REG(OUT_REG), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [WORDS];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour at the accepting edge: read-first, byte-lane write
    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [3:0] w, input logic [31:0] d);
        exp_t e;
        e.acc = cyc;
        if (a < ADDR_W'(WORDS)) begin
            e.data = mdl[a[3:0]];
            e.err  = 1'b0;
            for (int i = 0; i < 4; i++)
                if (w[i]) mdl[a[3:0]][8*i +: 8] = d[8*i +: 8];
        end else begin
            e.data = '0;
            e.err  = 1'b1;
        end
        sb.push_back(e);
    endtask

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                check_eq("stray_rsp", 64'(rsp_valid), 64'(0));
            end else if (rsp_ready) begin
                e = sb.pop_front();
                check_eq("rdata", 64'(rsp_rdata), 64'(e.data));
                check_eq("err", 64'(rsp_err), 64'(e.err));
                if (lat_chk) check_eq("latency", 64'(cyc - e.acc), 64'(2 + OUT_REG));
            end
        end
    end

    task automatic do_req(input logic [ADDR_W-1:0] a, input logic [3:0] w, input logic [31:0] d);
        bit done = 1'b0;
        req_valid = 1'b1; req_addr = a; req_wen = w; req_wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
        end
        if (!done) check_eq("req_timeout", 64'(0), 64'(1));
        else push_exp(a, w, d);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check_eq("drain_left", 64'(sb.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    // Called at posedge+1 right after rst falls
    task automatic wait_clear();
        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            check_eq("clr_init_done", 64'(init_done), 64'(0));
            check_eq("clr_req_ready", 64'(req_ready), 64'(0));
        end
        @(negedge clk);
        check_eq("run_init_done", 64'(init_done), 64'(1));
        check_eq("run_req_ready", 64'(req_ready), 64'(1));
        for (int i = 0; i < WORDS; i++) mdl[i] = '0;
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check_eq({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        check_eq({tag, "_rsp_err"},   64'(rsp_err),   64'(0));
        check_eq({tag, "_init_done"}, 64'(init_done), 64'(0));
    endtask

    initial begin
        int acc;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: clear sequence, then read a cleared word
        wait_clear();
        do_req(22'd5, 4'h0, '0);
        drain();

        // T2: full write, lane write, back-to-back read
        do_req(22'd3, 4'hF, 32'hDEADBEEF);
        do_req(22'd3, 4'h2, 32'h0000AA00);
        do_req(22'd3, 4'h0, '0);
        drain();

        // T3: preload then back-to-back reads with latency check
        for (int i = 0; i < 8; i++) do_req(ADDR_W'(i), 4'hF, 32'h11111111 * i);
        drain();
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) do_req(ADDR_W'(i), 4'h0, '0);
        drain();
        lat_chk = 1'b0;

        // T4: backpressure fills exactly DEPTH credits, then release in order
        rsp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1; req_wen = 4'h0; req_addr = 22'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid && sb.size() != 0) check_eq("t4_head_stable", 64'(rsp_rdata), 64'(sb[0].data));
            if (req_ready) begin
                push_exp(req_addr, req_wen, req_wdata);
                acc++;
            end
            @(posedge clk); #1;
            if (acc != 0) req_addr = ADDR_W'(1 + acc);
        end
        check_eq("t4_accepted", 64'(acc), 64'(DEPTH));
        check_eq("t4_req_ready", 64'(req_ready), 64'(0));
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // T5: out-of-range write ignored, error flagged
        do_req(22'd16, 4'hF, 32'h12345678);
        do_req(22'd0, 4'h0, '0);
        drain();

        // T6: reset with buffered responses, then reset mid-clear
        rsp_ready = 1'b0;
        do_req(22'd2, 4'h0, '0);
        do_req(22'd3, 4'h0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("t6_buffered", 64'(rsp_valid), 64'(1));
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_rst1");
        sb.delete();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_rst2");
        @(posedge clk); #1;
        rst = 1'b0;
        wait_clear();
        do_req(22'd3, 4'h0, '0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
